// File: rtl/pulse_sequencer_pkg.sv
// Shared types for the pulse sequencer: the descriptor popped from the core's
// descriptor FIFO and the sequencer FSM state encoding.
package pulse_sequencer_pkg;

    localparam int PULSE_REG_TSTART_W = 16;
    localparam int PULSE_MEM_ADDR_W   = 12;

    typedef struct packed {
        logic [PULSE_REG_TSTART_W-1:0] delay;
        logic [PULSE_MEM_ADDR_W-1:0]   pulse_mem_addr;
    } pulse_descriptor_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LEN,
        ST_WAIT,
        ST_PLAY
    } pulse_seq_state_t;

endpackage

// File: rtl/pulse_sequencer.sv
// Pops pulse descriptors, reads the pulse header and samples from pulse memory,
// waits the programmed delay and streams samples to the DAC at one per cycle.
module pulse_sequencer
    import pulse_sequencer_pkg::*;
#(
    parameter int DELAY_W     = PULSE_REG_TSTART_W,
    parameter int PMEM_ADDR_W = PULSE_MEM_ADDR_W,
    parameter int SAMPLE_W    = 16,
    parameter int LEN_W       = 12
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  pulse_descriptor_t      fifo_rdata,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    output logic                   pmem_en,
    output logic [PMEM_ADDR_W-1:0] pmem_addr,
    input  logic [SAMPLE_W-1:0]    pmem_rdata,
    output logic [SAMPLE_W-1:0]    dac_sample,
    output logic                   dac_valid,
    output logic                   busy,
    output logic [31:0]            pulse_count,
    output logic                   len_zero_err
);

    pulse_seq_state_t       state_q, state_d;
    logic [DELAY_W-1:0]     delay_q, delay_d;
    logic [DELAY_W-1:0]     cnt_q, cnt_d;
    logic [PMEM_ADDR_W-1:0] base_q, base_d;
    logic [PMEM_ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [LEN_W-1:0]       rem_q, rem_d;
    logic                   pmem_en_q, pmem_en_d;
    logic                   dac_valid_q, dac_valid_d;
    logic                   dac_last_q, dac_last_d;
    logic [SAMPLE_W-1:0]    dac_hold_q, dac_hold_d;
    logic [31:0]            pulse_count_q, pulse_count_d;
    logic                   len_zero_err_q, len_zero_err_d;

    logic                   pop;
    logic [LEN_W-1:0]       hdr_len;

    assign hdr_len = pmem_rdata[LEN_W-1:0];
    // Gated by reset so no descriptor is consumed while the block is held in reset.
    assign pop     = !reset && (state_q == ST_IDLE) && enable && !fifo_empty;

    always_comb begin
        state_d        = state_q;
        delay_d        = delay_q;
        cnt_d          = cnt_q;
        base_d         = base_q;
        addr_d         = addr_q;
        len_d          = len_q;
        rem_d          = rem_q;
        pmem_en_d      = 1'b0;
        len_zero_err_d = len_zero_err_q;

        case (state_q)
            ST_IDLE: begin
                if (pop) begin
                    delay_d   = DELAY_W'(fifo_rdata.delay);
                    base_d    = PMEM_ADDR_W'(fifo_rdata.pulse_mem_addr);
                    addr_d    = PMEM_ADDR_W'(fifo_rdata.pulse_mem_addr);
                    pmem_en_d = 1'b1;
                    state_d   = ST_HDR;
                end
            end
            ST_HDR: begin
                state_d = ST_LEN;
            end
            ST_LEN: begin
                len_d = hdr_len;
                cnt_d = delay_q;
                if (hdr_len == '0) begin
                    len_zero_err_d = 1'b1;
                end
                if (delay_q != '0) begin
                    state_d = ST_WAIT;
                end else if (hdr_len != '0) begin
                    pmem_en_d = 1'b1;
                    addr_d    = base_q + PMEM_ADDR_W'(1);
                    rem_d     = hdr_len - LEN_W'(1);
                    state_d   = ST_PLAY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - DELAY_W'(1);
                // Leaving on the count-of-one cycle makes WAIT last exactly `delay` cycles.
                if (cnt_q == DELAY_W'(1)) begin
                    if (len_q != '0) begin
                        pmem_en_d = 1'b1;
                        addr_d    = base_q + PMEM_ADDR_W'(1);
                        rem_d     = len_q - LEN_W'(1);
                        state_d   = ST_PLAY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PLAY: begin
                if (rem_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    pmem_en_d = 1'b1;
                    addr_d    = addr_q + PMEM_ADDR_W'(1);
                    rem_d     = rem_q - LEN_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The sample read issued in PLAY returns next cycle and goes straight to the DAC.
    always_comb begin
        dac_valid_d   = pmem_en_q && (state_q == ST_PLAY);
        dac_last_d    = pmem_en_q && (state_q == ST_PLAY) && (rem_q == '0);
        dac_hold_d    = dac_valid_q ? pmem_rdata : dac_hold_q;
        pulse_count_d = (dac_valid_q && dac_last_q) ? pulse_count_q + 32'd1 : pulse_count_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            delay_q        <= '0;
            cnt_q          <= '0;
            base_q         <= '0;
            addr_q         <= '0;
            len_q          <= '0;
            rem_q          <= '0;
            pmem_en_q      <= 1'b0;
            dac_valid_q    <= 1'b0;
            dac_last_q     <= 1'b0;
            dac_hold_q     <= '0;
            pulse_count_q  <= '0;
            len_zero_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_q        <= delay_d;
            cnt_q          <= cnt_d;
            base_q         <= base_d;
            addr_q         <= addr_d;
            len_q          <= len_d;
            rem_q          <= rem_d;
            pmem_en_q      <= pmem_en_d;
            dac_valid_q    <= dac_valid_d;
            dac_last_q     <= dac_last_d;
            dac_hold_q     <= dac_hold_d;
            pulse_count_q  <= pulse_count_d;
            len_zero_err_q <= len_zero_err_d;
        end
    end

    assign fifo_rd_en   = pop;
    assign pmem_en      = pmem_en_q;
    assign pmem_addr    = addr_q;
    assign dac_valid    = dac_valid_q;
    assign dac_sample   = dac_valid_q ? pmem_rdata : dac_hold_q;
    assign busy         = (state_q != ST_IDLE) || dac_valid_q;
    assign pulse_count  = pulse_count_q;
    assign len_zero_err = len_zero_err_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer: FIFO and pulse-memory models, a negedge
// monitor logging pops, reads and samples, and one task per scenario.
module tb_pulse_sequencer;
    import pulse_sequencer_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              enable = 1'b0;
    pulse_descriptor_t fifo_rdata;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic              pmem_en;
    logic [11:0]       pmem_addr;
    logic [15:0]       pmem_rdata = 16'h0;
    logic [15:0]       dac_sample;
    logic              dac_valid;
    logic              busy;
    logic [31:0]       pulse_count;
    logic              len_zero_err;

    pulse_sequencer #(
        .DELAY_W(16), .PMEM_ADDR_W(12), .SAMPLE_W(16), .LEN_W(12)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
        .pmem_en(pmem_en), .pmem_addr(pmem_addr), .pmem_rdata(pmem_rdata),
        .dac_sample(dac_sample), .dac_valid(dac_valid), .busy(busy),
        .pulse_count(pulse_count), .len_zero_err(len_zero_err)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:4095];
    always @(posedge clk) if (pmem_en) pmem_rdata <= mem[pmem_addr];

    pulse_descriptor_t fq [0:15];
    logic [3:0] wr_ptr = 4'd0;
    logic [3:0] rd_ptr = 4'd0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_rdata = fq[rd_ptr];
    always @(posedge clk) if (fifo_rd_en) rd_ptr <= rd_ptr + 4'd1;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_pop = 0, n_dac = 0, n_pa = 0, last_busy = -1, bad_pop = 0;
    int          pop_cyc [0:63];
    int          dac_cyc [0:63];
    logic [15:0] dac_val [0:63];
    logic [11:0] pa_log  [0:63];

    always @(negedge clk) begin
        if (fifo_rd_en) begin
            if (fifo_empty) bad_pop++;
            if (n_pop < 64) pop_cyc[n_pop] = cyc;
            n_pop++;
        end
        if (dac_valid) begin
            if (n_dac < 64) begin dac_cyc[n_dac] = cyc; dac_val[n_dac] = dac_sample; end
            n_dac++;
        end
        if (pmem_en) begin
            if (n_pa < 64) pa_log[n_pa] = pmem_addr;
            n_pa++;
        end
        if (busy) last_busy = cyc;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        n_pop = 0; n_dac = 0; n_pa = 0; last_busy = -1;
    endtask

    task automatic push(input logic [15:0] dly, input logic [11:0] addr);
        fq[wr_ptr].delay          = dly;
        fq[wr_ptr].pulse_mem_addr = addr;
        wr_ptr = wr_ptr + 4'd1;
        $display("[%0d] push descriptor delay=%0d addr=0x%03h", cyc, dly, addr);
    endtask

    task automatic wait_idle(input string name);
        bit done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            tick();
            if (!busy && (fifo_empty || !enable)) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_bad++; $display("FAIL %s_timeout: busy=%0b, required idle within 300 cycles", name, busy); end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick(); tick();
        n_cmp++; if ({fifo_rd_en, pmem_en, dac_valid, busy, len_zero_err} !== 5'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b required 00000", {fifo_rd_en, pmem_en, dac_valid, busy, len_zero_err}); end
        n_cmp++; if (pmem_addr !== 12'h0) begin n_bad++; $display("FAIL reset_addr: got %h required 000", pmem_addr); end
        n_cmp++; if (dac_sample !== 16'h0) begin n_bad++; $display("FAIL reset_sample: got %h required 0000", dac_sample); end
        n_cmp++; if (pulse_count !== 32'd0) begin n_bad++; $display("FAIL reset_count: got %0d required 0", pulse_count); end
        reset = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [15:0] exp_s [3] = '{16'hA1, 16'hA2, 16'hA3};
        clear_logs();
        push(16'd5, 12'h010);
        wait_idle("single");
        n_cmp++; if (n_pop !== 1) begin n_bad++; $display("FAIL single_pops: got %0d required 1", n_pop); end
        n_cmp++; if (n_dac !== 3) begin n_bad++; $display("FAIL single_nsamples: got %0d required 3", n_dac); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (dac_val[i] !== exp_s[i] || dac_cyc[i] !== pop_cyc[0] + 9 + i) begin
                n_bad++; $display("FAIL single_sample%0d: got %h@%0d required %h@%0d", i, dac_val[i], dac_cyc[i], exp_s[i], pop_cyc[0] + 9 + i); end
        end
        n_cmp++; if (pulse_count !== 32'd1) begin n_bad++; $display("FAIL single_count: got %0d required 1", pulse_count); end
        n_cmp++; if (last_busy !== pop_cyc[0] + 11) begin n_bad++; $display("FAIL single_busy_end: got %0d required %0d", last_busy, pop_cyc[0] + 11); end
        n_cmp++; if (dac_sample !== 16'hA3) begin n_bad++; $display("FAIL single_hold: got %h required 00a3", dac_sample); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_s [4] = '{16'hB1, 16'hB2, 16'hC1, 16'hC2};
        int          exp_c [4];
        clear_logs();
        push(16'd0, 12'h020);
        push(16'd0, 12'h030);
        wait_idle("b2b");
        exp_c = '{pop_cyc[0] + 4, pop_cyc[0] + 5, pop_cyc[0] + 9, pop_cyc[0] + 10};
        n_cmp++; if (n_pop !== 2) begin n_bad++; $display("FAIL b2b_pops: got %0d required 2", n_pop); end
        n_cmp++; if (pop_cyc[1] !== pop_cyc[0] + 5) begin n_bad++; $display("FAIL b2b_pop_gap: got %0d required %0d", pop_cyc[1], pop_cyc[0] + 5); end
        n_cmp++; if (n_dac !== 4) begin n_bad++; $display("FAIL b2b_nsamples: got %0d required 4", n_dac); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (dac_val[i] !== exp_s[i] || dac_cyc[i] !== exp_c[i]) begin
                n_bad++; $display("FAIL b2b_sample%0d: got %h@%0d required %h@%0d", i, dac_val[i], dac_cyc[i], exp_s[i], exp_c[i]); end
        end
        n_cmp++; if (pulse_count !== 32'd3) begin n_bad++; $display("FAIL b2b_count: got %0d required 3", pulse_count); end
    endtask

    task automatic test_len_zero();
        clear_logs();
        n_cmp++; if (len_zero_err !== 1'b0) begin n_bad++; $display("FAIL lz_pre: got %b required 0", len_zero_err); end
        push(16'd3, 12'h040);
        wait_idle("lz");
        n_cmp++; if (n_dac !== 0) begin n_bad++; $display("FAIL lz_nsamples: got %0d required 0", n_dac); end
        n_cmp++; if (len_zero_err !== 1'b1) begin n_bad++; $display("FAIL lz_err: got %b required 1", len_zero_err); end
        n_cmp++; if (pulse_count !== 32'd3) begin n_bad++; $display("FAIL lz_count: got %0d required 3", pulse_count); end
        n_cmp++; if (last_busy !== pop_cyc[0] + 5) begin n_bad++; $display("FAIL lz_idle_time: got %0d required %0d", last_busy, pop_cyc[0] + 5); end
    endtask

    task automatic test_addr_wrap();
        logic [11:0] exp_a [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
        logic [15:0] exp_s [3] = '{16'hD1, 16'hD2, 16'hD3};
        clear_logs();
        push(16'd0, 12'hFFE);
        wait_idle("wrap");
        n_cmp++; if (n_pa !== 4) begin n_bad++; $display("FAIL wrap_nreads: got %0d required 4", n_pa); end
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (pa_log[i] !== exp_a[i]) begin n_bad++; $display("FAIL wrap_addr%0d: got %h required %h", i, pa_log[i], exp_a[i]); end
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (dac_val[i] !== exp_s[i]) begin n_bad++; $display("FAIL wrap_sample%0d: got %h required %h", i, dac_val[i], exp_s[i]); end
        end
        n_cmp++; if (len_zero_err !== 1'b1) begin n_bad++; $display("FAIL wrap_sticky: got %b required 1", len_zero_err); end
        n_cmp++; if (pulse_count !== 32'd4) begin n_bad++; $display("FAIL wrap_count: got %0d required 4", pulse_count); end
    endtask

    task automatic test_enable_drop();
        bit seen = 1'b0;
        clear_logs();
        push(16'd2, 12'h010);
        push(16'd0, 12'h020);
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (dac_valid) seen = 1'b1;
        end
        enable = 1'b0;
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL en_play_timeout: dac_valid=%b required 1 within 40 cycles", dac_valid); end
        for (int i = 0; i < 20; i++) tick();
        n_cmp++; if (n_pop !== 1) begin n_bad++; $display("FAIL en_held_pops: got %0d required 1", n_pop); end
        n_cmp++; if (n_dac !== 3 || busy !== 1'b0) begin n_bad++; $display("FAIL en_completed: got %0d samples busy=%b required 3 busy=0", n_dac, busy); end
        n_cmp++; if (fifo_empty !== 1'b0) begin n_bad++; $display("FAIL en_fifo: got empty=%b required 0", fifo_empty); end
        enable = 1'b1;
        wait_idle("en");
        n_cmp++; if (n_pop !== 2 || n_dac !== 5) begin n_bad++; $display("FAIL en_resume: got %0d pops %0d samples required 2 / 5", n_pop, n_dac); end
        n_cmp++; if (dac_val[3] !== 16'hB1 || dac_cyc[3] !== pop_cyc[1] + 4) begin
            n_bad++; $display("FAIL en_resume_sample: got %h@%0d required 00b1@%0d", dac_val[3], dac_cyc[3], pop_cyc[1] + 4); end
        n_cmp++; if (pulse_count !== 32'd6) begin n_bad++; $display("FAIL en_count: got %0d required 6", pulse_count); end
    endtask

    task automatic test_reset_mid();
        bit popped = 1'b0;
        clear_logs();
        push(16'd10, 12'h010);
        push(16'd0, 12'h020);
        for (int i = 0; i < 20 && !popped; i++) begin
            tick();
            if (n_pop == 1) popped = 1'b1;
        end
        n_cmp++; if (!popped) begin n_bad++; $display("FAIL rst_pop_timeout: got %0d pops required 1", n_pop); end
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_in_wait: busy=%b required 1", busy); end
        reset = 1'b1;
        #1;
        n_cmp++; if ({fifo_rd_en, pmem_en, dac_valid, busy, len_zero_err} !== 5'b0 || pmem_addr !== 12'h0 || dac_sample !== 16'h0 || pulse_count !== 32'd0) begin
            n_bad++; $display("FAIL rst_mid_clear: got flags=%b addr=%h sample=%h count=%0d required 00000/000/0000/0",
                              {fifo_rd_en, pmem_en, dac_valid, busy, len_zero_err}, pmem_addr, dac_sample, pulse_count); end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++; if (n_pop !== 1) begin n_bad++; $display("FAIL rst_no_pop: got %0d pops required 1", n_pop); end
        clear_logs();
        reset = 1'b0;
        wait_idle("rst");
        n_cmp++; if (n_pop !== 1 || n_dac !== 2) begin n_bad++; $display("FAIL rst_replay: got %0d pops %0d samples required 1 / 2", n_pop, n_dac); end
        n_cmp++; if (dac_val[0] !== 16'hB1 || dac_cyc[0] !== pop_cyc[0] + 4 || dac_val[1] !== 16'hB2 || dac_cyc[1] !== pop_cyc[0] + 5) begin
            n_bad++; $display("FAIL rst_replay_samples: got %h@%0d %h@%0d required 00b1@%0d 00b2@%0d",
                              dac_val[0], dac_cyc[0], dac_val[1], dac_cyc[1], pop_cyc[0] + 4, pop_cyc[0] + 5); end
        n_cmp++; if (pulse_count !== 32'd1) begin n_bad++; $display("FAIL rst_count: got %0d required 1", pulse_count); end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0;
        mem[12'h010] = 16'd3; mem[12'h011] = 16'hA1; mem[12'h012] = 16'hA2; mem[12'h013] = 16'hA3;
        mem[12'h020] = 16'd2; mem[12'h021] = 16'hB1; mem[12'h022] = 16'hB2;
        mem[12'h030] = 16'd2; mem[12'h031] = 16'hC1; mem[12'h032] = 16'hC2;
        mem[12'h040] = 16'd0;
        mem[12'hFFE] = 16'd3; mem[12'hFFF] = 16'hD1; mem[12'h000] = 16'hD2; mem[12'h001] = 16'hD3;

        test_reset();
        test_single();
        test_back_to_back();
        test_len_zero();
        test_addr_wrap();
        test_enable_drop();
        test_reset_mid();

        n_cmp++; if (bad_pop !== 0) begin n_bad++; $display("FAIL pop_when_empty: got %0d required 0", bad_pop); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
